// File: rtl/wb_sequencer_if.sv
// Request, hazard-query and register-file write signals of the writeback sequencer.
interface wb_sequencer_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic        a_fp;
  logic [31:0] a_data;

  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic        b_fp;
  logic        b_dbl;
  logic [63:0] b_data;

  logic [4:0]  chk_addr;
  logic        chk_fp;
  logic        chk_hit;

  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [31:0] WrData;
  logic        ftpt_write;
  logic        busy;

  modport master (
    output a_valid, a_addr, a_fp, a_data,
    output b_valid, b_addr, b_fp, b_dbl, b_data,
    output chk_addr, chk_fp,
    input  a_ready, b_ready, chk_hit, WrEn, WrAddr, WrData, ftpt_write, busy
  );

  modport slave (
    input  a_valid, a_addr, a_fp, a_data,
    input  b_valid, b_addr, b_fp, b_dbl, b_data,
    input  chk_addr, chk_fp,
    output a_ready, b_ready, chk_hit, WrEn, WrAddr, WrData, ftpt_write, busy
  );
endinterface

// File: rtl/wb_sequencer.sv
// Two-port writeback queue draining one register write per cycle (2-cycle latency, or 1 with WB_BYPASS_EN);
// readiness comes from the registered count only, and port B needs two free slots while A is also valid.
module wb_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  wb_sequencer_if.slave bus
);
  typedef enum logic {IDLE, DBL_LO} state_t;

  typedef struct packed {
    logic        fp;
    logic        dbl;
    logic [4:0]  addr;
    logic [31:0] hi;
    logic [31:0] lo;
  } entry_t;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_M1   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_M2   = (AW+1)'(DEPTH - 2);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  state_t        state_q, state_d;

  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        ftpt_q, ftpt_d;
  logic [4:0]  lo_addr_q, lo_addr_d;
  logic [31:0] lo_data_q, lo_data_d;

  entry_t a_ent, b_ent, src;
  logic   a_acc, b_acc, a_enq, b_enq, a_push, b_push;
  logic   byp, byp_a, byp_b, pop, issue;

  assign bus.a_ready = rst && (count < CNT_FULL);
  assign bus.b_ready = rst && ((count <= CNT_M2) || ((count == CNT_M1) && !bus.a_valid));

  always_comb begin
    a_ent      = '0;
    a_ent.fp   = bus.a_fp;
    a_ent.addr = bus.a_addr;
    a_ent.hi   = bus.a_data;
    // a double always targets the FP file, even if b_fp was left low
    b_ent      = '0;
    b_ent.fp   = bus.b_fp | bus.b_dbl;
    b_ent.dbl  = bus.b_dbl;
    b_ent.addr = bus.b_addr;
    b_ent.hi   = bus.b_data[63:32];
    b_ent.lo   = bus.b_data[31:0];
  end

  // integer r0 completes its handshake but is never queued
  assign a_acc = bus.a_valid && bus.a_ready;
  assign b_acc = bus.b_valid && bus.b_ready;
  assign a_enq = a_acc && (a_ent.fp || (a_ent.addr != 5'd0));
  assign b_enq = b_acc && (b_ent.fp || (b_ent.addr != 5'd0));

`ifdef WB_BYPASS_EN
  assign byp = (state_q == IDLE) && (count == '0) && (a_enq || b_enq);
`else
  assign byp = 1'b0;
`endif
  assign byp_a  = byp && a_enq;
  assign byp_b  = byp && !a_enq;
  assign a_push = a_enq && !byp_a;
  assign b_push = b_enq && !byp_b;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    issue     = 1'b0;
    src       = mem[rd_ptr];
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ftpt_d    = ftpt_q;
    lo_addr_d = lo_addr_q;
    lo_data_d = lo_data_q;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          issue = 1'b1;
          pop   = 1'b1;
        end else if (byp) begin
          issue = 1'b1;
          src   = a_enq ? a_ent : b_ent;
        end
      end
      DBL_LO: begin
        wr_en_d   = 1'b1;
        wr_addr_d = lo_addr_q;
        wr_data_d = lo_data_q;
        ftpt_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      wr_en_d   = 1'b1;
      wr_addr_d = src.dbl ? {src.addr[4:1], 1'b0} : src.addr;
      wr_data_d = src.hi;
      ftpt_d    = src.fp;
      if (src.dbl) begin
        lo_addr_d = {src.addr[4:1], 1'b1};
        lo_data_d = src.lo;
        state_d   = DBL_LO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ftpt_q    <= 1'b0;
      lo_addr_q <= '0;
      lo_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count     <= count + (AW+1)'(a_push) + (AW+1)'(b_push) - (AW+1)'(pop);
      rd_ptr    <= rd_ptr + AW'(pop);
      wr_ptr    <= wr_ptr + AW'(a_push) + AW'(b_push);
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ftpt_q    <= ftpt_d;
      lo_addr_q <= lo_addr_d;
      lo_data_q <= lo_data_d;
    end
  end

  // A is always stored ahead of B when both land in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      if (a_push) mem[wr_ptr] <= a_ent;
      if (b_push) mem[wr_ptr + AW'(a_push)] <= b_ent;
    end
  end

  // hazard covers queued entries plus the odd half still owed by DBL_LO
  logic          hit;
  logic [AW-1:0] idx;
  entry_t        e;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    e   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      e   = mem[idx];
      if (((AW+1)'(i) < count) && (e.fp == bus.chk_fp) &&
          (e.dbl ? (e.addr[4:1] == bus.chk_addr[4:1]) : (e.addr == bus.chk_addr)))
        hit = 1'b1;
    end
    if ((state_q == DBL_LO) && bus.chk_fp && (bus.chk_addr == lo_addr_q))
      hit = 1'b1;
  end

  assign bus.chk_hit    = hit;
  assign bus.WrEn       = wr_en_q;
  assign bus.WrAddr     = wr_addr_q;
  assign bus.WrData     = wr_data_q;
  assign bus.ftpt_write = ftpt_q;
  assign bus.busy       = (count != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed scenarios plus random traffic against a word-queue reference model.
module tb_wb_sequencer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  wb_sequencer_if bus();

  wb_sequencer #(.DEPTH(DEPTH), .AW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: every register write still owed, in issue order; 'first' marks the word that pops its entry.
  typedef struct {
    bit        fp;
    bit [4:0]  addr;
    bit [31:0] data;
    bit        first;
  } word_t;

  word_t     q[$];
  bit        m_en;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit        m_fp;
  bit        started = 1'b0;
  int        n_checks = 0;
  int        n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    foreach (q[i]) if (q[i].first) c++;
    return c;
  endfunction

  function automatic bit m_a_ready();
    return rst && (m_count() < DEPTH);
  endfunction

  function automatic bit m_b_ready();
    int c = m_count();
    return rst && ((c <= DEPTH - 2) || ((c == DEPTH - 1) && !bus.a_valid));
  endfunction

  function automatic bit m_hit();
    foreach (q[i]) if (q[i].fp == bus.chk_fp && q[i].addr == bus.chk_addr) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_all();
    check("a_ready", 32'(bus.a_ready), 32'(m_a_ready()));
    check("b_ready", 32'(bus.b_ready), 32'(m_b_ready()));
    check("chk_hit", 32'(bus.chk_hit), 32'(m_hit()));
    check("busy", 32'(bus.busy), 32'(q.size() != 0));
    check("WrEn", 32'(bus.WrEn), 32'(m_en));
    check("WrAddr", 32'(bus.WrAddr), 32'(m_addr));
    check("WrData", bus.WrData, m_data);
    check("ftpt_write", 32'(bus.ftpt_write), 32'(m_fp));
  endtask

  task automatic model_edge(input bit a_acc, input bit b_acc);
    word_t nw[$];
    word_t w;
    bit    fp;
    if (!rst) begin
      q.delete();
      m_en = 0; m_addr = 0; m_data = 0; m_fp = 0;
      return;
    end
    if (a_acc && (bus.a_fp || bus.a_addr != 0)) begin
      w.fp = bus.a_fp; w.addr = bus.a_addr; w.data = bus.a_data; w.first = 1;
      nw.push_back(w);
    end
    if (b_acc) begin
      fp = bus.b_fp | bus.b_dbl;
      if (bus.b_dbl) begin
        w.fp = 1; w.addr = {bus.b_addr[4:1], 1'b0}; w.data = bus.b_data[63:32]; w.first = 1;
        nw.push_back(w);
        w.fp = 1; w.addr = {bus.b_addr[4:1], 1'b1}; w.data = bus.b_data[31:0]; w.first = 0;
        nw.push_back(w);
      end else if (fp || bus.b_addr != 0) begin
        w.fp = fp; w.addr = bus.b_addr; w.data = bus.b_data[63:32]; w.first = 1;
        nw.push_back(w);
      end
    end
`ifdef WB_BYPASS_EN
    if (q.size() == 0) begin
      foreach (nw[i]) q.push_back(nw[i]);
      nw.delete();
    end
`endif
    m_en = 0;
    if (q.size() != 0) begin
      w = q.pop_front();
      m_en = 1; m_addr = w.addr; m_data = w.data; m_fp = w.fp;
    end
    foreach (nw[i]) q.push_back(nw[i]);
  endtask

  // Inputs are driven just after posedge; checks happen on the negedge.
  task automatic cycle();
    bit aa, ba;
    @(negedge clk);
    if (started) compare_all();
    aa = bus.a_valid && m_a_ready();
    ba = bus.b_valid && m_b_ready();
    @(posedge clk);
    #1;
    model_edge(aa, ba);
    started = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 0; bus.b_valid = 0; bus.b_dbl = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && bus.busy === 1'b1; i++) cycle();
    check("drain_idle", 32'(bus.busy), 32'd0);
  endtask

  logic [31:0] w32;

  initial begin
    rst = 0;
    bus.a_valid = 0; bus.a_addr = 0; bus.a_fp = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = 0; bus.b_fp = 0; bus.b_dbl = 0; bus.b_data = 0;
    bus.chk_addr = 0; bus.chk_fp = 0;

    // reset, then a single integer write
    cycle(); cycle();
    check("rst_wren", 32'(bus.WrEn), 32'd0);
    check("rst_wraddr", 32'(bus.WrAddr), 32'd0);
    check("rst_wrdata", bus.WrData, 32'd0);
    check("rst_ftpt", 32'(bus.ftpt_write), 32'd0);
    check("rst_a_ready", 32'(bus.a_ready), 32'd0);
    rst = 1;
    bus.a_valid = 1; bus.a_addr = 5; bus.a_fp = 0; bus.a_data = 32'hDEADBEEF;
    cycle();
    idle_inputs();
`ifndef WB_BYPASS_EN
    check("t1_wren_early", 32'(bus.WrEn), 32'd0);
    cycle();
`endif
    check("t1_wren", 32'(bus.WrEn), 32'd1);
    check("t1_wraddr", 32'(bus.WrAddr), 32'd5);
    check("t1_wrdata", bus.WrData, 32'hDEADBEEF);
    check("t1_ftpt", 32'(bus.ftpt_write), 32'd0);
    cycle();
    check("t1_wren_off", 32'(bus.WrEn), 32'd0);
    check("t1_hold_data", bus.WrData, 32'hDEADBEEF);

    // double split into FP r6 / r7
    bus.b_valid = 1; bus.b_dbl = 1; bus.b_fp = 1; bus.b_addr = 7;
    bus.b_data = 64'h11111111_22222222;
    cycle();
    idle_inputs();
    bus.chk_fp = 1;
`ifndef WB_BYPASS_EN
    bus.chk_addr = 6; #1;
    check("t2_hit6", 32'(bus.chk_hit), 32'd1);
    bus.chk_addr = 7; #1;
    check("t2_hit7", 32'(bus.chk_hit), 32'd1);
    cycle();
`endif
    check("t2_even_addr", 32'(bus.WrAddr), 32'd6);
    check("t2_even_data", bus.WrData, 32'h11111111);
    check("t2_even_ftpt", 32'(bus.ftpt_write), 32'd1);
    bus.chk_addr = 7; #1;
    check("t2_hit7_pending", 32'(bus.chk_hit), 32'd1);
    cycle();
    check("t2_odd_wren", 32'(bus.WrEn), 32'd1);
    check("t2_odd_addr", 32'(bus.WrAddr), 32'd7);
    check("t2_odd_data", bus.WrData, 32'h22222222);
    #1;
    check("t2_hit7_done", 32'(bus.chk_hit), 32'd0);

    // simultaneous A and B: A first (single-word B carries its word in both halves)
    drain();
    bus.a_valid = 1; bus.a_addr = 3; bus.a_fp = 0; bus.a_data = 32'hA;
    bus.b_valid = 1; bus.b_addr = 4; bus.b_fp = 0; bus.b_dbl = 0; bus.b_data = {32'hB, 32'hB};
    cycle();
    idle_inputs();
`ifndef WB_BYPASS_EN
    cycle();
`endif
    check("t3_first_addr", 32'(bus.WrAddr), 32'd3);
    check("t3_first_data", bus.WrData, 32'hA);
    cycle();
    check("t3_second_addr", 32'(bus.WrAddr), 32'd4);
    check("t3_second_data", bus.WrData, 32'hB);

    // backpressure: A plus double B every cycle
    drain();
    bus.a_valid = 1; bus.a_fp = 0; bus.a_addr = 9; bus.a_data = 32'h55;
    bus.b_valid = 1; bus.b_dbl = 1; bus.b_fp = 1; bus.b_addr = 12; bus.b_data = 64'h1_0000_0002;
    cycle(); cycle();
    #1;
    check("t4_a_ready_cnt3", 32'(bus.a_ready), 32'd1);
    check("t4_b_ready_cnt3", 32'(bus.b_ready), 32'd0);
    cycle(); cycle();
    #1;
    check("t4_a_ready_full", 32'(bus.a_ready), 32'd0);
    idle_inputs();
    drain();

    // integer r0 is dropped, FP r0 is written
    bus.a_valid = 1; bus.a_fp = 0; bus.a_addr = 0; bus.a_data = 32'h123;
    bus.chk_fp = 0; bus.chk_addr = 0; #1;
    check("t5_a_ready", 32'(bus.a_ready), 32'd1);
    cycle();
    idle_inputs();
    #1;
    check("t5_hit_r0", 32'(bus.chk_hit), 32'd0);
    cycle(); cycle();
    check("t5_no_write", 32'(bus.WrEn), 32'd0);
    bus.a_valid = 1; bus.a_fp = 1; bus.a_addr = 0; bus.a_data = 32'h456;
    cycle();
    idle_inputs();
`ifndef WB_BYPASS_EN
    cycle();
`endif
    check("t5_fp0_wren", 32'(bus.WrEn), 32'd1);
    check("t5_fp0_ftpt", 32'(bus.ftpt_write), 32'd1);
    check("t5_fp0_data", bus.WrData, 32'h456);

    // reset while the odd half is pending
    drain();
    bus.b_valid = 1; bus.b_dbl = 1; bus.b_fp = 1; bus.b_addr = 9; bus.b_data = 64'hAAAA_0000_BBBB_0000;
    cycle();
    idle_inputs();
`ifndef WB_BYPASS_EN
    cycle();
`endif
    check("t6_even_addr", 32'(bus.WrAddr), 32'd8);
    rst = 0;
    cycle();
    check("t6_wren_rst", 32'(bus.WrEn), 32'd0);
    check("t6_busy_rst", 32'(bus.busy), 32'd0);
    rst = 1;
    cycle();
    check("t6_no_odd", 32'(bus.WrEn), 32'd0);

    // random traffic, occasional reset
    for (int n = 0; n < 3000; n++) begin
      bus.a_valid  = ($urandom_range(0, 99) < 55);
      bus.a_addr   = 5'($urandom_range(0, 7));
      bus.a_fp     = 1'($urandom_range(0, 1));
      bus.a_data   = $urandom;
      bus.b_valid  = ($urandom_range(0, 99) < 45);
      bus.b_dbl    = ($urandom_range(0, 2) == 0);
      bus.b_fp     = ($urandom_range(0, 3) != 0);
      bus.b_addr   = 5'($urandom_range(0, 7));
      w32          = $urandom;
      bus.b_data   = bus.b_dbl ? {w32, 32'($urandom)} : {w32, w32};
      bus.chk_fp   = 1'($urandom_range(0, 1));
      bus.chk_addr = 5'($urandom_range(0, 7));
      rst          = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst = 1;
    idle_inputs();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed so far", n_fail, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
Writeback-side producer for the integer/FP register file. It accepts writeback requests from two execution sources over valid/ready handshakes and buffers them in a small FIFO. It drains one register write per cycle onto the register-file write port (WrAddr/WrEn/WrData/ftpt_write). It splits double-precision results into two single-word writes, drops integer r0 writes, and exposes a pending-write hazard query for decode.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
AW, 2, log2(DEPTH).

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous reset, active-low (rst==0 at posedge resets).
a_valid  in  1  port A (ALU) request valid.
a_ready  out  1  port A can accept.
a_addr  in  5  destination register.
a_fp  in  1  1 = FP file, 0 = integer file.
a_data  in  32  write data.
b_valid  in  1  port B (mem/FP unit) request valid.
b_ready  out  1  port B can accept.
b_addr  in  5  destination register; LSB ignored when b_dbl=1.
b_fp  in  1  1 = FP file.
b_dbl  in  1  double-precision pair write; legal only with b_fp=1.
b_data  in  64  bits [0:31] go to the even register, bits [32:63] to the odd register.
chk_addr  in  5  hazard query register.
chk_fp  in  1  hazard query file select.
chk_hit  out  1  combinational: a queued or in-flight write targets (chk_fp, chk_addr).
WrEn  out  1  register-file write enable, registered.
WrAddr  out  5  register-file write address, registered.
WrData  out  32  register-file write data, registered.
ftpt_write  out  1  register-file bank select, registered.
busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (rst==0): FIFO empty, count=0, FSM=IDLE. WrEn=0, WrAddr=0, WrData=0, ftpt_write=0. a_ready=0 and b_ready=0 during reset. A reset mid-double discards the pending low word.
- Readiness is computed from the registered count only; a same-cycle pop is not credited.
  - a_ready = count<DEPTH.
  - b_ready = (count<=DEPTH-2) or (count==DEPTH-1 and !a_valid).
- Accept: on a posedge with valid&ready. If both ports are accepted in the same cycle, A is enqueued ahead of B.
- Integer r0 filter: a request with fp=0 and addr=0 is accepted (handshake completes) but is not enqueued. chk_hit is never raised for it.
- A port-A entry is stored with dbl=0.
- FSM:
  - IDLE: if FIFO non-empty, pop head and register outputs. WrEn=1, WrAddr=addr, ftpt_write=fp, WrData=data[0:31]. If the head has dbl=1, WrAddr={addr[0:3],0}, save data[32:63], go to DBL_LO. Otherwise stay in IDLE. If the FIFO is empty, WrEn=0.
  - DBL_LO: WrEn=1, WrAddr={addr[0:3],1}, ftpt_write=1, WrData=saved low word. Go to IDLE; no pop occurs this cycle.
- Throughput is one register write per cycle. A double costs two cycles.
- Latency: request accepted at edge k; WrEn high in the cycle following edge k+1 if the FIFO was empty and the FSM was IDLE.
- The register file samples on negedge; outputs are stable for the full cycle.
- WrEn is deasserted the cycle after the last write. WrAddr, WrData and ftpt_write hold their last values while WrEn=0.
- chk_hit covers all valid FIFO entries plus the DBL_LO pending word. A double entry matches both its even and odd registers. chk_hit does not include the current registered output (already committed by the negedge write).
- An illegal b_dbl=1 with b_fp=0 is treated as b_fp=1.

Optional Feature:
WB_BYPASS_EN
- Defined: when the FIFO is empty, the FSM is IDLE and a single request is accepted (A preferred), it loads the output registers directly at edge k. WrEn is high the cycle after acceptance (1-cycle latency) and the request is not enqueued. The second request in a simultaneous A+B accept is enqueued normally.
- Undefined: all requests pass through the FIFO (2-cycle latency).

Test Plan:
1. Reset then single write: rst=0 for 2 cycles, then a_valid with addr=5, fp=0, data=0xDEADBEEF -> WrEn=1, WrAddr=5, ftpt_write=0, WrData=0xDEADBEEF for exactly one cycle, 2 cycles after accept (1 with WB_BYPASS_EN). All outputs are 0 during reset.
2. Double split: b_dbl=1, b_fp=1, b_addr=7, b_data=0x11111111_22222222 -> write to FP r6 = 0x11111111, then FP r7 = 0x22222222 on consecutive cycles. chk_hit=1 for chk_fp=1 with chk_addr 6 and 7 until issued.
3. Simultaneous accept: A(r3=0xA) and B(r4=0xB) in the same cycle with an empty FIFO -> r3 written before r4, one cycle apart.
4. Full/backpressure: DEPTH=4, hold a_valid with outputs draining -> a_ready falls at count=4. With count=3 and A+B both valid: only A is accepted and b_ready=0. No request is lost or duplicated.
5. r0 filter: a_valid with fp=0, addr=0 -> a_ready=1, handshake completes, WrEn stays 0 and chk_hit(0,0)=0. FP r0 (fp=1, addr=0) is written normally.
6. Reset mid-double: assert rst=0 in the DBL_LO cycle -> WrEn=0 next cycle, odd word never written, busy=0 after reset.
